config_load_sequencer: RTL and testbench

//  Sequences the per-tile configuration memory: accepts a stream of 64-bit config words,

---
 rtl/config_load_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_config_load_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_load_sequencer.sv
// ---------------------------------------------------------------------------
// config_load_sequencer
//
// Loads a tile's configuration memory from a valid/ready stream of config
// words (one consecutive address per accepted word), then runs execution by
// asserting start_exec and sweeping the read address over the loaded words
// for a programmed number of cycles.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   load_req             pulse: start loading a new configuration (IDLE only)
//   cfg_valid/cfg_ready  config word handshake, transfer = valid & ready
//   cfg_data, cfg_last   config word and end-of-configuration marker
//   run_req, run_cycles  pulse: run the loaded configuration for run_cycles
//   abort                leave LOAD/ARM/RUN and return to IDLE
//   control_mem_*        address / write data / bit enables / strobes
//   start_exec           execution active (ARM and RUN)
//   operation            6'b011110 during the ARM cycle, else 0
//   busy                 sequencer not idle
//   loaded               a complete configuration is present
//   done                 one-cycle pulse when a run completes normally
//   overflow_err         sticky: DEPTH words accepted without cfg_last
//
// Every output is a flop. The output logic decodes the *next* state so the
// registered outputs line up with the state they describe.
// ---------------------------------------------------------------------------
module config_load_sequencer #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 32,
   parameter int ADDR_BITS  = $clog2(DEPTH),
   parameter int CNT_BITS   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_req,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [DATA_WIDTH-1:0] cfg_data,
   input  logic                  cfg_last,
   input  logic                  run_req,
   input  logic [CNT_BITS-1:0]   run_cycles,
   input  logic                  abort,
   output logic [ADDR_BITS-1:0]  control_mem_addr,
   output logic [DATA_WIDTH-1:0] control_mem_data_in,
   output logic [DATA_WIDTH-1:0] control_mem_bit_en,
   output logic                  control_mem_wr_en,
   output logic                  control_mem_en,
   output logic                  start_exec,
   output logic [5:0]            operation,
   output logic                  busy,
   output logic                  loaded,
   output logic                  done,
   output logic                  overflow_err
);

   localparam int                   CW       = ADDR_BITS + 1;
   localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(DEPTH - 1);
   localparam logic [5:0]           ARM_OP   = 6'b011110;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARM,
      S_RUN,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   // Bookkeeping state
   logic [ADDR_BITS-1:0]  idx_q, idx_d;
   logic [CW-1:0]         word_count_q, word_count_d;
   logic [CNT_BITS-1:0]   run_cnt_q, run_cnt_d;
   logic                  loaded_q, loaded_d;
   logic                  overflow_q, overflow_d;

   // Registered outputs
   logic                  cfg_ready_q, cfg_ready_d;
   logic [ADDR_BITS-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] bit_en_q, bit_en_d;
   logic                  wr_en_q, wr_en_d;
   logic                  en_q, en_d;
   logic                  start_exec_q, start_exec_d;
   logic [5:0]            operation_q, operation_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  xfer;
   logic                  run_wrap;

   // cfg_ready_q is only ever high while in LOAD, so this is the handshake.
   assign xfer = (state_q == S_LOAD) && cfg_valid && cfg_ready_q;

   // Read address wraps after the last loaded word (word_count = 1 holds 0).
   assign run_wrap = (({1'b0, addr_q} + CW'(1)) >= word_count_q);

   // State register and all other flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         word_count_q <= '0;
         run_cnt_q    <= '0;
         loaded_q     <= 1'b0;
         overflow_q   <= 1'b0;
         cfg_ready_q  <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         bit_en_q     <= '0;
         wr_en_q      <= 1'b0;
         en_q         <= 1'b0;
         start_exec_q <= 1'b0;
         operation_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         word_count_q <= word_count_d;
         run_cnt_q    <= run_cnt_d;
         loaded_q     <= loaded_d;
         overflow_q   <= overflow_d;
         cfg_ready_q  <= cfg_ready_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         bit_en_q     <= bit_en_d;
         wr_en_q      <= wr_en_d;
         en_q         <= en_d;
         start_exec_q <= start_exec_d;
         operation_q  <= operation_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Next-state and bookkeeping
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      word_count_d = word_count_q;
      run_cnt_d    = run_cnt_q;
      loaded_d     = loaded_q;
      overflow_d   = overflow_q;

      case (state_q)
         S_IDLE: begin
            // load_req has priority over run_req
            if (load_req) begin
               state_d    = S_LOAD;
               idx_d      = '0;
               loaded_d   = 1'b0;
               overflow_d = 1'b0;
            end else if (run_req && loaded_q) begin
               state_d   = S_ARM;
               run_cnt_d = (run_cycles == '0) ? CNT_BITS'(1) : run_cycles;
            end
         end
         S_LOAD: begin
            if (xfer) begin
               idx_d = idx_q + ADDR_BITS'(1);
            end
            // A word accepted together with abort is still written, but the
            // configuration is considered incomplete.
            if (abort) begin
               state_d  = S_IDLE;
               loaded_d = 1'b0;
            end else if (xfer && cfg_last) begin
               state_d      = S_IDLE;
               word_count_d = {1'b0, idx_q} + CW'(1);
               loaded_d     = 1'b1;
            end else if (xfer && (idx_q == LAST_IDX)) begin
               state_d    = S_IDLE;
               overflow_d = 1'b1;
               loaded_d   = 1'b0;
            end
         end
         S_ARM: begin
            state_d = abort ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            // run_cnt_q counts the RUN cycles still to go, including this one
            if (abort) begin
               state_d = S_IDLE;
            end else if (run_cnt_q <= CNT_BITS'(1)) begin
               state_d = S_DONE;
            end else begin
               run_cnt_d = run_cnt_q - CNT_BITS'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode, registered
   always_comb begin
      cfg_ready_d  = (state_d == S_LOAD);
      busy_d       = (state_d != S_IDLE);
      addr_d       = '0;
      data_d       = '0;
      bit_en_d     = '0;
      wr_en_d      = 1'b0;
      en_d         = 1'b0;
      start_exec_d = 1'b0;
      operation_d  = '0;
      done_d       = 1'b0;

      // One-cycle write latency: the accepted word is presented next cycle.
      if (xfer) begin
         wr_en_d  = 1'b1;
         en_d     = 1'b1;
         bit_en_d = '1;
         addr_d   = idx_q;
         data_d   = cfg_data;
      end

      case (state_d)
         S_ARM: begin
            start_exec_d = 1'b1;
            en_d         = 1'b1;
            addr_d       = '0;
            operation_d  = ARM_OP;
         end
         S_RUN: begin
            start_exec_d = 1'b1;
            en_d         = 1'b1;
            if (state_q == S_RUN) begin
               addr_d = run_wrap ? '0 : (addr_q + ADDR_BITS'(1));
            end else begin
               addr_d = '0;
            end
         end
         S_DONE: begin
            done_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign cfg_ready           = cfg_ready_q;
   assign control_mem_addr    = addr_q;
   assign control_mem_data_in = data_q;
   assign control_mem_bit_en  = bit_en_q;
   assign control_mem_wr_en   = wr_en_q;
   assign control_mem_en      = en_q;
   assign start_exec          = start_exec_q;
   assign operation           = operation_q;
   assign busy                = busy_q;
   assign loaded              = loaded_q;
   assign done                = done_q;
   assign overflow_err        = overflow_q;

endmodule

// File: tb/tb_config_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_config_load_sequencer
//
// Scenario tasks drive config_load_sequencer with randomized config words,
// stall patterns and run lengths. Expected memory writes come from a queue of
// the words the bench offered; expected run traces come from a cycle-by-cycle
// model of the ARM / RUN / DONE timeline (address = step mod word count).
// ---------------------------------------------------------------------------
module tb_config_load_sequencer;

   localparam int DW    = 64;
   localparam int DEPTH = 32;
   localparam int AB    = 5;
   localparam int CB    = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_req, cfg_valid, cfg_last, run_req, abort;
   logic [DW-1:0] cfg_data;
   logic [CB-1:0] run_cycles;
   logic          cfg_ready, control_mem_wr_en, control_mem_en, start_exec;
   logic          busy, loaded, done, overflow_err;
   logic [AB-1:0] control_mem_addr;
   logic [DW-1:0] control_mem_data_in, control_mem_bit_en;
   logic [5:0]    operation;

   config_load_sequencer #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_BITS(AB), .CNT_BITS(CB)
   ) dut (
      .clk(clk), .reset(reset), .load_req(load_req), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
      .run_req(run_req), .run_cycles(run_cycles), .abort(abort),
      .control_mem_addr(control_mem_addr), .control_mem_data_in(control_mem_data_in),
      .control_mem_bit_en(control_mem_bit_en), .control_mem_wr_en(control_mem_wr_en),
      .control_mem_en(control_mem_en), .start_exec(start_exec), .operation(operation),
      .busy(busy), .loaded(loaded), .done(done), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AB-1:0] addr;
      logic [DW-1:0] data;
      logic [DW-1:0] bit_en;
      logic          en;
   } wr_t;

   typedef struct packed {
      logic [AB-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   wr_t  wr_obs[$];
   exp_t exp_q[$];
   wr_t  mon_w;

   int n_cmp  = 0;
   int n_fail = 0;
   int rdy_bad;

   // trace bits: {start_exec, operation[5:0], en, done, busy, wr_en}
   logic [10:0]   tr_ctl[64];
   logic [AB-1:0] tr_addr[64];
   logic [10:0]   ex_ctl[64];
   int            ex_addr[64];

   // Every memory write seen on the interface
   always @(negedge clk) begin
      if (control_mem_wr_en === 1'b1) begin
         mon_w.addr   = control_mem_addr;
         mon_w.data   = control_mem_data_in;
         mon_w.bit_en = control_mem_bit_en;
         mon_w.en     = control_mem_en;
         wr_obs.push_back(mon_w);
      end
   end

   // Offer n words (cfg_last on the n-th if with_last). Every word offered in
   // LOAD is expected to be accepted and written; words past DEPTH are not.
   task automatic load_words(input int n, input bit with_last, input bit stall);
      int i;
      int cyc;
      bit v;
      logic [DW-1:0] d;
      exp_t e;
      exp_q.delete();
      wr_obs.delete();
      rdy_bad  = 0;
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      i   = 0;
      cyc = int'($urandom_range(1, 0));
      while (i < n) begin
         v = stall ? (cyc % 2 == 0) : 1'b1;
         d = {$urandom, $urandom};
         cfg_valid = v;
         cfg_data  = d;
         cfg_last  = with_last && (i == n - 1);
         if (v) begin
            if (cfg_ready !== ((i < DEPTH) ? 1'b1 : 1'b0)) rdy_bad++;
            if (i < DEPTH) begin
               e.addr = AB'(i);
               e.data = d;
               exp_q.push_back(e);
            end
         end
         @(negedge clk);
         if (v) i++;
         cyc++;
      end
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      cfg_data  = '0;
      @(negedge clk);
   endtask

   task automatic run_trace(input int rc, input int ncyc, input int abort_at);
      run_cycles = CB'(rc);
      run_req    = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         run_req    = 1'b0;
         tr_ctl[i]  = {start_exec, operation, control_mem_en, done, busy, control_mem_wr_en};
         tr_addr[i] = control_mem_addr;
         abort      = (i == abort_at);
      end
      abort = 1'b0;
   endtask

   // Timeline: 1 ARM cycle, max(rc,1) RUN cycles, 1 DONE cycle, then idle.
   // An abort seen in cycle abort_at leaves everything idle afterwards.
   task automatic model_run(input int rc, input int wc, input int abort_at, input int ncyc);
      int n;
      n = (rc == 0) ? 1 : rc;
      for (int i = 0; i < ncyc; i++) begin
         ex_ctl[i]  = '0;
         ex_addr[i] = -1;
         if (!(abort_at >= 0 && i > abort_at)) begin
            if (i == 0) begin
               ex_ctl[i]  = {1'b1, 6'd30, 1'b1, 1'b0, 1'b1, 1'b0};
               ex_addr[i] = 0;
            end else if (i <= n) begin
               ex_ctl[i]  = {1'b1, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0};
               ex_addr[i] = (i - 1) % wc;
            end else if (i == n + 1) begin
               ex_ctl[i] = {1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0};
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      load_req = 0; cfg_valid = 0; cfg_last = 0; run_req = 0; abort = 0;
      cfg_data = '0; run_cycles = '0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({cfg_ready, control_mem_wr_en, control_mem_en, start_exec, busy, loaded, done, overflow_err} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b want 00000000", {cfg_ready, control_mem_wr_en, control_mem_en, start_exec, busy, loaded, done, overflow_err});
      end
      n_cmp++;
      if ({operation, control_mem_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_op_addr: got op=%b addr=%0d want 0", operation, control_mem_addr);
      end
      n_cmp++;
      if ({control_mem_data_in, control_mem_bit_en} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got data=%h bit_en=%h want 0", control_mem_data_in, control_mem_bit_en);
      end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy, cfg_ready, start_exec} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_idle: got busy/ready/exec=%b want 000", {busy, cfg_ready, start_exec});
      end
   endtask

   task automatic test_load(input string name, input int n, input bit stall);
      load_words(n, 1'b1, stall);
      n_cmp++;
      if (wr_obs.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL %s write_count: got %0d want %0d", name, wr_obs.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < wr_obs.size(); k++) begin
         n_cmp++;
         if ({wr_obs[k].addr, wr_obs[k].data, wr_obs[k].bit_en, wr_obs[k].en} !==
             {exp_q[k].addr, exp_q[k].data, {DW{1'b1}}, 1'b1}) begin
            n_fail++;
            $display("FAIL %s write%0d: got addr=%0d data=%h be=%h en=%b want addr=%0d data=%h be=all-ones en=1",
                     name, k, wr_obs[k].addr, wr_obs[k].data, wr_obs[k].bit_en, wr_obs[k].en,
                     exp_q[k].addr, exp_q[k].data);
         end
      end
      n_cmp++;
      if ({loaded, overflow_err, busy, cfg_ready, rdy_bad != 0} !== 5'b10000) begin
         n_fail++;
         $display("FAIL %s status: got loaded/ovf/busy/ready/ready_err=%b want 10000", name,
                  {loaded, overflow_err, busy, cfg_ready, rdy_bad != 0});
      end
   endtask

   task automatic test_run(input string name, input int rc, input int wc, input int abort_at);
      int ncyc;
      ncyc = ((rc == 0) ? 1 : rc) + 3;
      run_trace(rc, ncyc, abort_at);
      model_run(rc, wc, abort_at, ncyc);
      for (int i = 0; i < ncyc; i++) begin
         n_cmp++;
         if (tr_ctl[i] !== ex_ctl[i] || (ex_addr[i] >= 0 && tr_addr[i] !== AB'(ex_addr[i]))) begin
            n_fail++;
            $display("FAIL %s cycle%0d: got ctl=%b addr=%0d want ctl=%b addr=%0d",
                     name, i, tr_ctl[i], tr_addr[i], ex_ctl[i], ex_addr[i]);
         end
      end
      n_cmp++;
      if (loaded !== 1'b1) begin
         n_fail++;
         $display("FAIL %s loaded_after: got %b want 1", name, loaded);
      end
   endtask

   task automatic test_load_stall();
      test_load("load_stall", 6, 1'b1);
   endtask

   task automatic test_load_basic();
      test_load("load_basic", 4, 1'b0);
   endtask

   task automatic test_run_basic();
      test_run("run10", 10, 4, -1);
   endtask

   task automatic test_run_boundaries();
      test_run("run_zero", 0, 4, -1);
      test_load("load_one", 1, 1'b0);
      test_run("run_wc1", 3, 1, -1);
   endtask

   task automatic test_abort_run();
      test_load("load_abort", 4, 1'b0);
      test_run("abort_run", 10, 4, 5);
      test_run("rerun", 3, 4, -1);
   endtask

   task automatic test_overflow();
      load_words(33, 1'b0, 1'b0);
      n_cmp++;
      if (wr_obs.size() != DEPTH) begin
         n_fail++;
         $display("FAIL ovf write_count: got %0d want %0d", wr_obs.size(), DEPTH);
      end
      for (int k = 0; k < exp_q.size() && k < wr_obs.size(); k++) begin
         n_cmp++;
         if ({wr_obs[k].addr, wr_obs[k].data} !== {exp_q[k].addr, exp_q[k].data}) begin
            n_fail++;
            $display("FAIL ovf write%0d: got addr=%0d data=%h want addr=%0d data=%h",
                     k, wr_obs[k].addr, wr_obs[k].data, exp_q[k].addr, exp_q[k].data);
         end
      end
      n_cmp++;
      if ({overflow_err, loaded, busy, cfg_ready, rdy_bad != 0} !== 5'b10000) begin
         n_fail++;
         $display("FAIL ovf status: got ovf/loaded/busy/ready/ready_err=%b want 10000",
                  {overflow_err, loaded, busy, cfg_ready, rdy_bad != 0});
      end
      run_trace(5, 6, -1);
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (tr_ctl[i] !== 11'd0) begin
            n_fail++;
            $display("FAIL ovf run_ignored cycle%0d: got ctl=%b want 0", i, tr_ctl[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      for (int it = 0; it < 3; it++) begin
         n = int'($urandom_range(DEPTH, 1));
         test_load("rand_load", n, 1'($urandom_range(1, 0)));
         test_run("rand_run_a", int'($urandom_range(40, 0)), n, -1);
         test_run("rand_run_b", int'($urandom_range(40, 0)), n, -1);
      end
   endtask

   task automatic test_reset_mid_load();
      load_req = 1'b1;
      @(negedge clk);
      load_req  = 1'b0;
      cfg_valid = 1'b1;
      cfg_data  = {$urandom, $urandom};
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({control_mem_wr_en, control_mem_en, cfg_ready, busy, loaded, start_exec} !== 6'b000000) begin
         n_fail++;
         $display("FAIL midreset_ctl: got wr/en/ready/busy/loaded/exec=%b want 000000",
                  {control_mem_wr_en, control_mem_en, cfg_ready, busy, loaded, start_exec});
      end
      n_cmp++;
      if ({control_mem_addr, control_mem_data_in, control_mem_bit_en} !== '0) begin
         n_fail++;
         $display("FAIL midreset_data: got addr=%0d data=%h be=%h want 0",
                  control_mem_addr, control_mem_data_in, control_mem_bit_en);
      end
      @(negedge clk);
      reset     = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = '0;
      run_trace(4, 5, -1);
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (tr_ctl[i] !== 11'd0) begin
            n_fail++;
            $display("FAIL midreset_idle cycle%0d: got ctl=%b want 0", i, tr_ctl[i]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_stall();
      test_load_basic();
      test_run_basic();
      test_run_boundaries();
      test_abort_run();
      test_overflow();
      test_back_to_back();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
